ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
PS/2 keyboard receive front end. It oversamples the ps2_clk/ps2_data lines in the system clock domain and deserialises 11-bit device-to-host frames. Valid scan-code bytes are pushed into a small FIFO. It sits directly upstream of the keyboard FSM / scan-code decoder, which consumes data/ready and pops with nextdata_n.

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W = 8 entries.
- SYNC_STAGES, 3, flip-flop stages on ps2_clk and ps2_data before edge detection (minimum 2).
- TIMEOUT_CYC, 100000, system clocks with no ps2_clk falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all state on posedge clk.
- clrn  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- nextdata_n  in  1  active-low pop request from consumer.
- data  out  8  FIFO head byte (scan code); valid only while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a valid frame was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: a frame was discarded for a start, parity, stop or timeout error.

Behaviour:
- Reset (clrn=0, async): synchroniser regs=1, bit counter=0, timeout counter=0, FIFO pointers=0.
- Reset outputs: ready=0, overflow=0, frame_err=0, data=8'h00.
- Reset mid-frame drops the partial frame. No byte is emitted after release until a fresh start bit arrives.
- Sampling: a falling edge is synchronised ps2_clk going 1 then 0 over consecutive samples. On that cycle, shift in synchronised ps2_data.
- Receiver states:
  - IDLE: first falling edge with data=0 → RECV, bit count 1. Falling edge with data=1 → stay IDLE, frame_err pulse.
  - RECV: bits 1-8 fill the data byte LSB first; bit 9 is parity; bit 10 is stop → CHECK.
  - CHECK (1 cycle): valid iff XOR(data byte, parity)=1 (odd parity) and stop=1.
    - Valid → push request.
    - Invalid → frame_err=1 for this cycle, nothing pushed.
    - Either way → IDLE.
- Timeout: in RECV, the counter resets on every falling edge. On reaching TIMEOUT_CYC-1 → IDLE, frame_err pulse.
- Latency: ready rises on the 2nd clk after the cycle that detects the 11th (stop) falling edge: CHECK cycle, then FIFO write.
- Pop: on each clk with nextdata_n=0 and ready=1, read pointer +1. A consumer holding nextdata_n low pops once per clock. Pop while empty is ignored.
- Push:
  - When not full, write at the write pointer and increment it.
  - When full, the byte is dropped and overflow is set.
  - Push and pop in the same cycle: the pop is applied first, so a push while full with a simultaneous pop is accepted and overflow is not set.
  - Push and pop on an empty FIFO: the pop is ignored and the push is accepted.
- Pointers are ADDR_W+1 bits:
  - empty when equal;
  - full when MSBs differ and the lower bits are equal;
  - wrap-around is natural.
- data is the combinational read of the head entry.
- overflow clears on the next successful pop, or on reset.
- F0/E0 prefixes are not interpreted; every valid byte is queued.

Decomposition:
- Shared package: PS2_FRAME_BITS=11, receiver state encodings (IDLE, RECV, CHECK), PS2_BREAK=8'hF0, PS2_EXT=8'hE0. The downstream FSM uses the same constants.
- One natural sub-module, sync_fifo (ADDR_W, 8-bit width): push, pop, full, empty, dout.
- Frame receiver and timeout logic stay in ps2_rx_fifo.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1: start, data LSB first, parity 0, stop) at 12.5 kHz → ready=1 two clocks after 11th edge, data=8'h1C; nextdata_n low 1 cycle → ready=0.
- Frames F0 then 1C, no pop → data=8'hF0, ready=1; after one pop, data=8'h1C; after second pop, ready=0.
- Frame 0x1C with parity bit flipped to 1 → frame_err single-cycle pulse, ready stays 0, FIFO unchanged.
- 9 frames 0x01..0x09 with no pop → overflow=1 after 9th; 8 pops return 01..08, overflow clears on first pop, ready=0 after 8th.
- 5 edges of a frame, then ps2_clk idle high > TIMEOUT_CYC → frame_err pulse; subsequent full frame 0x2A received correctly.
- clrn pulsed low after bit 6 of a frame with 2 bytes queued → ready=0, overflow=0 immediately (async); remaining edges of the broken frame do not create a byte; next full frame 0x33 → data=8'h33.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
// ============================================================================
// ps2_rx_fifo_pkg : shared PS/2 frame constants and receiver state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package ps2_rx_fifo_pkg;

    localparam int          PS2_FRAME_BITS = 11;
    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam logic [7:0]  PS2_EXT        = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    // The parity bit makes the total count of ones across data and parity odd.
    function automatic logic odd_parity_ok(input logic [8:0] par_and_data);
        return ^par_and_data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with extra-MSB pointers and sticky overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_pop_w;
    logic               do_push_w;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // A pop frees a slot before the push is judged, so full+pop+push is accepted.
    assign do_pop_w  = pop_i && !empty_o;
    assign do_push_w = push_i && (!full_o || do_pop_w);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_pop_w) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            overflow_d = 1'b0;
        end
        if (do_push_w) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (push_i) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push_w) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= din_i;
        end
    end

    assign dout_o     = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ============================================================================
// ps2_rx_fifo : PS/2 device-to-host frame receiver feeding a scan-code FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int          TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall_w;
    logic                   bit_w;

    rx_state_e              state_q;
    logic [3:0]             bit_cnt_q;
    logic [8:0]             shift_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   push_q;
    logic                   frame_err_q;
    logic                   empty_w;
    logic                   full_w;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_w = clk_prev_q && !clk_sync_q[SYNC_STAGES-1];
    assign bit_w  = dat_sync_q[SYNC_STAGES-1];

    // Validity is judged on the stop edge so push/frame_err are registered
    // and visible during the single CHECK cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    to_cnt_q <= '0;
                    if (fall_w) begin
                        if (!bit_w) begin
                            state_q   <= ST_RECV;
                            bit_cnt_q <= 4'd1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (fall_w) begin
                        to_cnt_q  <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == STOP_IDX) begin
                            push_q      <= odd_parity_ok(shift_q) && bit_w;
                            frame_err_q <= !(odd_parity_ok(shift_q) && bit_w);
                            state_q     <= ST_CHECK;
                        end else begin
                            shift_q <= {bit_w, shift_q[8:1]};
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        to_cnt_q    <= '0;
                        bit_cnt_q   <= '0;
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    bit_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .ADDR_W (ADDR_W),
        .WIDTH  (8)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (clrn),
        .push_i     (push_q),
        .pop_i      (!nextdata_n),
        .din_i      (shift_q[7:0]),
        .dout_o     (data),
        .full_o     (full_w),
        .empty_o    (empty_w),
        .overflow_o (overflow)
    );

    assign ready     = !empty_w;
    assign frame_err = frame_err_q;

    logic unused_w;
    assign unused_w = full_w;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
// tb_ps2_rx_fifo : scoreboard bench for the PS/2 receive FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_rx_fifo;

    localparam int SYNC = 3;
    localparam int TOUT = 600;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         pop_cnt = 0;
    bit         rand_pop = 1'b0;
    int         err_cnt = 0;
    int         err_run = 0;
    int         err_run_max = 0;

    ps2_rx_fifo #(
        .ADDR_W      (3),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Frame layout: [0]=start, [8:1]=data LSB first, [9]=odd parity, [10]=stop.
    function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (exp_q.size() < 8) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endfunction

    task automatic ps2_fall(input logic v);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic ps2_rise();
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] fr;
        fr = mkframe(b, bad_par);
        for (int i = 0; i < 11; i++) begin
            ps2_fall(fr[i]);
            if (i == 10 && !bad_par) model_push(b);
            ps2_rise();
        end
    endtask

    task automatic do_pops(input int n);
        int w;
        pop_cnt = n;
        w = 0;
        while (pop_cnt > 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (pop_cnt > 0) begin
            total++;
            bad++;
            $display("FAIL pop_timeout got=%0d pending want=0", pop_cnt);
            pop_cnt = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops whenever the consumer is willing and compares against the model.
    initial begin
        forever begin
            @(negedge clk);
            nextdata_n = 1'b1;
            if (clrn && ready && (pop_cnt > 0 || (rand_pop && $urandom_range(1, 0) == 1))) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte got=%0h want=none", data);
                end else begin
                    chk("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
                exp_ovf = 1'b0;
                if (pop_cnt > 0) pop_cnt--;
                nextdata_n = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (frame_err) begin
            err_cnt++;
            err_run++;
            if (err_run > err_run_max) err_run_max = err_run;
        end else begin
            err_run = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        int          lat;
        int          e0;
        int          nbad;
        logic [7:0]  b;
        bit          badp;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        chk("rst_data", {24'd0, data}, 0);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        // 0x1C with latency measurement from the stop edge
        fr = mkframe(8'h1C, 1'b0);
        chk("frame_1c_bits", {21'd0, fr}, {21'd0, 11'b10000111000});
        for (int i = 0; i < 10; i++) begin
            ps2_fall(fr[i]);
            ps2_rise();
        end
        ps2_fall(fr[10]);
        model_push(8'h1C);
        lat = 0;
        while (!ready && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat < SYNC + 1 || lat > SYNC + 3) begin
            bad++;
            $display("FAIL ready_latency got=%0d want=%0d..%0d", lat, SYNC + 1, SYNC + 3);
        end
        chk("data_1c", {24'd0, data}, 32'h1C);
        ps2_rise();
        do_pops(1);
        chk("ready_after_pop", {31'd0, ready}, 0);

        // F0 then 1C queued
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        chk("two_ready", {31'd0, ready}, 1);
        chk("head_f0", {24'd0, data}, 32'hF0);
        do_pops(1);
        chk("head_1c", {24'd0, data}, 32'h1C);
        do_pops(1);
        chk("two_empty", {31'd0, ready}, 0);

        // parity error
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        chk("parity_err_count", err_cnt - e0, 1);
        chk("parity_no_byte", {31'd0, ready}, 0);

        // overflow
        for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b0);
        chk("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("ovf_ready", {31'd0, ready}, 1);
        do_pops(1);
        chk("ovf_clear", {31'd0, overflow}, 0);
        do_pops(7);
        chk("ovf_drained", {31'd0, ready}, 0);

        // timeout
        e0 = err_cnt;
        fr = mkframe(8'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ps2_fall(fr[i]);
            ps2_rise();
        end
        repeat (TOUT + 100) @(negedge clk);
        chk("timeout_err", err_cnt - e0, 1);
        send_frame(8'h2A, 1'b0);
        chk("after_to_ready", {31'd0, ready}, 1);
        do_pops(1);
        chk("after_to_empty", {31'd0, ready}, 0);

        // async reset mid-frame
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        chk("pre_rst_ready", {31'd0, ready}, 1);
        fr = mkframe(8'hC0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            ps2_fall(fr[i]);
            ps2_rise();
        end
        @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        chk("async_rst_ready", {31'd0, ready}, 0);
        chk("async_rst_ovf", {31'd0, overflow}, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        e0 = err_cnt;
        for (int i = 7; i < 11; i++) begin
            ps2_fall(fr[i]);
            ps2_rise();
        end
        repeat (20) @(negedge clk);
        chk("broken_no_byte", {31'd0, ready}, 0);
        chk("broken_errs", err_cnt - e0, 4);
        send_frame(8'h33, 1'b0);
        chk("post_rst_data", {24'd0, data}, 32'h33);
        do_pops(1);

        // randomized traffic with a free-running consumer
        rand_pop = 1'b1;
        e0 = err_cnt;
        nbad = 0;
        repeat (25) begin
            b = 8'($urandom);
            badp = ($urandom_range(4, 0) == 0);
            if (badp) nbad++;
            send_frame(b, badp);
            repeat ($urandom_range(30, 0)) @(negedge clk);
        end
        rand_pop = 1'b0;
        repeat (4) @(negedge clk);
        do_pops(exp_q.size());
        chk("rand_drained", {31'd0, ready}, 0);
        chk("rand_errs", err_cnt - e0, nbad);
        chk("rand_ovf", {31'd0, overflow}, 0);
        chk("err_pulse_width", err_run_max, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
